// File: rtl/lsu_sequencer_pkg.sv
// Shared control-bus layout, access-size codes and sequencer state encoding
// for the memory-stage load/store sequencer.
package lsu_sequencer_pkg;

  localparam int CTRL_W       = 5;
  localparam int MEM_RD       = 0;
  localparam int MEM_WR       = 1;
  localparam int MEM_SIZE_LO  = 2;
  localparam int MEM_SIZE_HI  = 3;
  localparam int MEM_UNSIGNED = 4;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_sequencer_lane.sv
// Per-slot combinational lane: byte enables, replicated store data, alignment
// check, and load lane extraction with sign/zero extension.
module lsu_lane
  import lsu_sequencer_pkg::*;
(
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       ld_word,
  output logic              mem_op,
  output logic              is_store,
  output logic              misalign,
  output logic [3:0]        be,
  output logic [31:0]       wdata,
  output logic [31:0]       result
);

  logic       access;
  logic       bad_align;
  logic [1:0] size;
  logic [1:0] off;
  logic [31:0] lane;
  logic [31:0] ext;

  always_comb begin
    access    = ctrl[MEM_RD] | ctrl[MEM_WR];
    size      = ctrl[MEM_SIZE_HI:MEM_SIZE_LO];
    off       = addr[1:0];
    bad_align = 1'b0;
    be        = 4'b1111;
    wdata     = store_data;
    case (size)
      MEM_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      MEM_HALF: begin
        be        = 4'b0011 << off;
        wdata     = {2{store_data[15:0]}};
        bad_align = off[0];
      end
      default: bad_align = |off;
    endcase

    misalign = access & bad_align;
    mem_op   = access & ~bad_align;
    is_store = ctrl[MEM_WR];

    lane = ld_word >> {off, 3'b000};
    case (size)
      MEM_BYTE: ext = ctrl[MEM_UNSIGNED] ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      MEM_HALF: ext = ctrl[MEM_UNSIGNED] ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:  ext = lane;
    endcase

    // Stores and suppressed (misaligned) accesses pass the ALU value through.
    result = (ctrl[MEM_RD] & ~ctrl[MEM_WR] & ~bad_align) ? ext : addr;
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Memory-stage sequencer: serves slot 0 then slot 1 through one single-port
// data memory, stalling the pipeline until the bundle's accesses complete.
//
// state | meaning
// IDLE  | new bundle visible; first pending op is requested directly from here
// REQ0  | slot 0 request held until accepted
// WAIT0 | slot 0 load waiting for read data
// REQ1  | slot 1 request held until accepted
// WAIT1 | slot 1 load waiting for read data
// DONE  | bundle complete, results stable until the backend advances
module lsu_sequencer
  import lsu_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              backend_we_i,
  input  logic [CTRL_W-1:0] ctrl0_lsu_i,
  input  logic [CTRL_W-1:0] ctrl1_lsu_i,
  input  logic [31:0]       alu_0_lsu_i,
  input  logic [31:0]       alu_1_lsu_i,
  input  logic [31:0]       store_data_0_i,
  input  logic [31:0]       store_data_1_i,
  output logic              mem_stall_o,
  output logic [31:0]       result_0_o,
  output logic [31:0]       result_1_o,
  output logic              misalign_0_o,
  output logic              misalign_1_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);

  lsu_state_e  state;
  lsu_state_e  after_0;
  logic [31:0] ld_data_0, ld_data_1;
  logic        mem_0, mem_1, st_0, st_1;
  logic [3:0]  be_0, be_1;
  logic [31:0] wdata_0, wdata_1;
  logic        sel_1;
  logic        req_active;
  logic [31:0] addr_sel;

  lsu_lane u_lane_0 (
    .ctrl       (ctrl0_lsu_i),
    .addr       (alu_0_lsu_i),
    .store_data (store_data_0_i),
    .ld_word    (ld_data_0),
    .mem_op     (mem_0),
    .is_store   (st_0),
    .misalign   (misalign_0_o),
    .be         (be_0),
    .wdata      (wdata_0),
    .result     (result_0_o)
  );

  lsu_lane u_lane_1 (
    .ctrl       (ctrl1_lsu_i),
    .addr       (alu_1_lsu_i),
    .store_data (store_data_1_i),
    .ld_word    (ld_data_1),
    .mem_op     (mem_1),
    .is_store   (st_1),
    .misalign   (misalign_1_o),
    .be         (be_1),
    .wdata      (wdata_1),
    .result     (result_1_o)
  );

  // IDLE doubles as the first request cycle so a bundle never pays an
  // extra evaluation cycle of stall.
  always_comb begin
    after_0      = mem_1 ? ST_REQ1 : ST_DONE;
    sel_1        = (state == ST_REQ1) || ((state == ST_IDLE) && !mem_0);
    req_active   = (state == ST_REQ0) || (state == ST_REQ1) ||
                   ((state == ST_IDLE) && (mem_0 || mem_1));
    dmem_req_o   = reset_n_i && req_active;
    addr_sel     = sel_1 ? alu_1_lsu_i : alu_0_lsu_i;
    dmem_addr_o  = ADDR_W'({addr_sel[31:2], 2'b00});
    dmem_be_o    = sel_1 ? be_1 : be_0;
    dmem_wdata_o = sel_1 ? wdata_1 : wdata_0;
    dmem_we_o    = sel_1 ? st_1 : st_0;
    mem_stall_o  = (state == ST_IDLE) ? (mem_0 || mem_1) : (state != ST_DONE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      ld_data_0 <= '0;
      ld_data_1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_0) begin
            if (dmem_ready_i) state <= st_0 ? after_0 : ST_WAIT0;
            else              state <= ST_REQ0;
          end else if (mem_1) begin
            if (dmem_ready_i) state <= st_1 ? ST_DONE : ST_WAIT1;
            else              state <= ST_REQ1;
          end
        end
        ST_REQ0: begin
          if (dmem_ready_i) state <= st_0 ? after_0 : ST_WAIT0;
        end
        ST_WAIT0: begin
          if (dmem_rvalid_i) begin
            ld_data_0 <= dmem_rdata_i;
            state     <= after_0;
          end
        end
        ST_REQ1: begin
          if (dmem_ready_i) state <= st_1 ? ST_DONE : ST_WAIT1;
        end
        ST_WAIT1: begin
          if (dmem_rvalid_i) begin
            ld_data_1 <= dmem_rdata_i;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (backend_we_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: scripted memory handshakes with
// hand-computed expectations checked by immediate assertions.
module tb_lsu_sequencer;

  // ctrl = {UNSIGNED, SIZE[1:0], WR, RD}
  localparam logic [4:0] C_NONE = 5'h00;
  localparam logic [4:0] C_LW   = 5'h09;
  localparam logic [4:0] C_LB   = 5'h01;
  localparam logic [4:0] C_LBU  = 5'h11;
  localparam logic [4:0] C_LH   = 5'h05;
  localparam logic [4:0] C_LHU  = 5'h15;
  localparam logic [4:0] C_SB   = 5'h02;
  localparam logic [4:0] C_SH   = 5'h06;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        backend_we;
  logic [4:0]  ctrl0, ctrl1;
  logic [31:0] alu0, alu1, sd0, sd1;
  logic        stall;
  logic [31:0] res0, res1;
  logic        mis0, mis1;
  logic        req, we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready, rvalid;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_sequencer #(.ADDR_W(32)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .backend_we_i   (backend_we),
    .ctrl0_lsu_i    (ctrl0),
    .ctrl1_lsu_i    (ctrl1),
    .alu_0_lsu_i    (alu0),
    .alu_1_lsu_i    (alu1),
    .store_data_0_i (sd0),
    .store_data_1_i (sd1),
    .mem_stall_o    (stall),
    .result_0_o     (res0),
    .result_1_o     (res1),
    .misalign_0_o   (mis0),
    .misalign_1_o   (mis1),
    .dmem_req_o     (req),
    .dmem_we_o      (we),
    .dmem_addr_o    (addr),
    .dmem_be_o      (be),
    .dmem_wdata_o   (wdata),
    .dmem_ready_i   (ready),
    .dmem_rvalid_i  (rvalid),
    .dmem_rdata_i   (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic bundle(input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] d1);
    ctrl0 = c0; alu0 = a0; sd0 = d0;
    ctrl1 = c1; alu1 = a1; sd1 = d1;
  endtask

  task automatic advance();
    backend_we = 1'b1;
    cyc();
    backend_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; backend_we = 1'b0; ready = 1'b0; rvalid = 1'b0; rdata = '0;
    bundle(C_NONE, 32'h0, 32'h0, C_NONE, 32'h0, 32'h0);
    cyc(); cyc();
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req",   {31'd0, req},   32'd0);
    rst_n = 1'b1;
    cyc();

    // LW 0x100 + ALU result 5, zero-wait memory
    bundle(C_LW, 32'h100, 32'h0, C_NONE, 32'd5, 32'h0);
    ready = 1'b1;
    #1;
    chk("lw_c1_stall", {31'd0, stall}, 32'd1);
    chk("lw_c1_req",   {31'd0, req},   32'd1);
    chk("lw_c1_addr",  addr,           32'h100);
    chk("lw_c1_be",    {28'd0, be},    32'hF);
    chk("lw_c1_we",    {31'd0, we},    32'd0);
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
    #1;
    chk("lw_c2_stall", {31'd0, stall}, 32'd1);
    chk("lw_c2_req",   {31'd0, req},   32'd0);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("lw_done_stall", {31'd0, stall}, 32'd0);
    chk("lw_res0",       res0,           32'hDEADBEEF);
    chk("lw_res1",       res1,           32'd5);
    advance();

    // SB 0x1AB @0x103 then LBU @0x103: store must precede load
    bundle(C_SB, 32'h103, 32'h1AB, C_LBU, 32'h103, 32'h0);
    ready = 1'b1;
    #1;
    chk("sb_req",   {31'd0, req},   32'd1);
    chk("sb_we",    {31'd0, we},    32'd1);
    chk("sb_addr",  addr,           32'h100);
    chk("sb_be",    {28'd0, be},    32'h8);
    chk("sb_wdata", wdata,          32'hABABABAB);
    chk("sb_stall", {31'd0, stall}, 32'd1);
    cyc();
    #1;
    chk("lbu_req",   {31'd0, req},   32'd1);
    chk("lbu_we",    {31'd0, we},    32'd0);
    chk("lbu_be",    {28'd0, be},    32'h8);
    chk("lbu_stall", {31'd0, stall}, 32'd1);
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'hAB223344;
    #1;
    chk("lbu_wait_stall", {31'd0, stall}, 32'd1);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("sb_lbu_stall", {31'd0, stall}, 32'd0);
    chk("lbu_res1",     res1,           32'h000000AB);
    chk("sb_res0",      res0,           32'h103);
    advance();

    // LH 0x202 + LB 0x203 from word 0x80010000: two loads, 4 stall cycles
    bundle(C_LH, 32'h202, 32'h0, C_LB, 32'h203, 32'h0);
    ready = 1'b1;
    #1;
    chk("lh_c1_stall", {31'd0, stall}, 32'd1);
    chk("lh_c1_be",    {28'd0, be},    32'hC);
    chk("lh_c1_addr",  addr,           32'h200);
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
    #1;
    chk("lh_c2_stall", {31'd0, stall}, 32'd1);
    cyc();
    rvalid = 1'b0; ready = 1'b1;
    #1;
    chk("lb_c3_stall", {31'd0, stall}, 32'd1);
    chk("lb_c3_req",   {31'd0, req},   32'd1);
    chk("lb_c3_be",    {28'd0, be},    32'h8);
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
    #1;
    chk("lb_c4_stall", {31'd0, stall}, 32'd1);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("lhlb_done_stall", {31'd0, stall}, 32'd0);
    chk("lh_res0",         res0,           32'hFFFF8001);
    chk("lb_res1",         res1,           32'hFFFFFF80);
    advance();

    // LHU 0x202 from the same word
    bundle(C_LHU, 32'h202, 32'h0, C_NONE, 32'h99, 32'h0);
    ready = 1'b1;
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
    cyc();
    rvalid = 1'b0;
    #1;
    chk("lhu_stall", {31'd0, stall}, 32'd0);
    chk("lhu_res0",  res0,           32'h00008001);
    chk("lhu_res1",  res1,           32'h99);
    advance();

    // Misaligned LW 0x101 and SH 0x203: no access, no stall
    bundle(C_LW, 32'h101, 32'h0, C_SH, 32'h203, 32'h1234);
    ready = 1'b1;
    #1;
    chk("mis_flag0", {31'd0, mis0},  32'd1);
    chk("mis_flag1", {31'd0, mis1},  32'd1);
    chk("mis_req",   {31'd0, req},   32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_res0",  res0,           32'h101);
    chk("mis_res1",  res1,           32'h203);
    cyc();
    ready = 1'b0;
    #1;
    chk("mis_req_later", {31'd0, req}, 32'd0);
    advance();

    // SH 0x302 with ready held low for 3 cycles
    bundle(C_SH, 32'h302, 32'hCAFE1234, C_NONE, 32'h11, 32'h0);
    ready = 1'b0;
    #1;
    chk("sh_mis0", {31'd0, mis0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sh_hold%0d_stall", i), {31'd0, stall}, 32'd1);
      chk($sformatf("sh_hold%0d_req", i),   {31'd0, req},   32'd1);
      chk($sformatf("sh_hold%0d_addr", i),  addr,           32'h300);
      chk($sformatf("sh_hold%0d_be", i),    {28'd0, be},    32'hC);
      chk($sformatf("sh_hold%0d_wdata", i), wdata,          32'h12341234);
      cyc();
      #1;
    end
    ready = 1'b1;
    #1;
    chk("sh_accept_req", {31'd0, req}, 32'd1);
    cyc();
    ready = 1'b0;
    #1;
    chk("sh_done_stall", {31'd0, stall}, 32'd0);
    advance();

    // Reset while waiting for load data, then a late rvalid
    bundle(C_LW, 32'h400, 32'h0, C_NONE, 32'h0, 32'h0);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    bundle(C_NONE, 32'h0, 32'h0, C_NONE, 32'h0, 32'h0);
    #1;
    chk("rstw_req_in_rst", {31'd0, req}, 32'd0);
    cyc();
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h55555555;
    #1;
    chk("late_rv_stall", {31'd0, stall}, 32'd0);
    chk("late_rv_req",   {31'd0, req},   32'd0);
    cyc();
    rvalid = 1'b0;
    #1;
    chk("late_rv_stall2", {31'd0, stall}, 32'd0);

    // Backend held for 2 cycles after DONE, then a new store bundle
    bundle(C_LW, 32'h500, 32'h0, C_NONE, 32'h77, 32'h0);
    ready = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, req}, 32'd1);
    cyc();
    ready = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
    cyc();
    rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("hold%0d_stall", i), {31'd0, stall}, 32'd0);
      chk($sformatf("hold%0d_req", i),   {31'd0, req},   32'd0);
      chk($sformatf("hold%0d_res0", i),  res0,           32'h0BADF00D);
      chk($sformatf("hold%0d_res1", i),  res1,           32'h77);
      cyc();
    end
    advance();
    bundle(C_SB, 32'h501, 32'h5A, C_NONE, 32'h0, 32'h0);
    ready = 1'b1;
    #1;
    chk("next_req",   {31'd0, req},   32'd1);
    chk("next_we",    {31'd0, we},    32'd1);
    chk("next_be",    {28'd0, be},    32'h2);
    chk("next_wdata", wdata,          32'h5A5A5A5A);
    chk("next_stall", {31'd0, stall}, 32'd1);
    cyc();
    ready = 1'b0;
    #1;
    chk("next_done_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
